// File: rtl/uart_tx_arbiter.sv
// Arbiter and load sequencer for the single TX UART: cfg replies have strict
// priority, fwd/evt share a round-robin slot, one packet is in flight at a time.
module uart_tx_arbiter #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic             txclk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [WIDTH-2:0] cfg_data,
  output logic             cfg_ack,
  input  logic             fwd_valid,
  input  logic [WIDTH-2:0] fwd_data,
  output logic             fwd_ack,
  input  logic             evt_valid,
  input  logic [WIDTH-2:0] evt_data,
  output logic             evt_ack,
  input  logic             tx_enable,
  input  logic             tx_busy,
  output logic             ld_tx_data,
  output logic [WIDTH-2:0] tx_data,
  output logic [1:0]       grant,
  output logic [7:0]       timeout_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CFG  = 2'b01;
  localparam logic [1:0] GNT_FWD  = 2'b10;
  localparam logic [1:0] GNT_EVT  = 2'b11;

  localparam logic [3:0] WAIT_LAST = 4'(BUSY_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-2:0] tx_data_q, tx_data_d;
  logic [1:0]       grant_q, grant_d;
  logic             ld_q, ld_d;
  logic             cfg_ack_q, cfg_ack_d;
  logic             fwd_ack_q, fwd_ack_d;
  logic             evt_ack_q, evt_ack_d;
  logic             evt_last_q, evt_last_d;  // 1: evt won the last fwd/evt grant
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [7:0]       timeout_q, timeout_d;

  logic [1:0]       winner;
  logic [WIDTH-2:0] winner_data;

  always_comb begin
    winner      = GNT_NONE;
    winner_data = '0;
    if (cfg_valid) begin
      winner      = GNT_CFG;
      winner_data = cfg_data;
    end else if (fwd_valid && (!evt_valid || evt_last_q)) begin
      winner      = GNT_FWD;
      winner_data = fwd_data;
    end else if (evt_valid) begin
      winner      = GNT_EVT;
      winner_data = evt_data;
    end
  end

  // NOTE: every _d gets a default before the case so no path can infer a latch;
  // strobes default to 0 so they live for exactly one cycle.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    evt_last_d = evt_last_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    ld_d       = 1'b0;
    cfg_ack_d  = 1'b0;
    fwd_ack_d  = 1'b0;
    evt_ack_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tx_enable && !tx_busy && (winner != GNT_NONE)) begin
          state_d   = S_LOAD;
          tx_data_d = winner_data;
          grant_d   = winner;
          ld_d      = 1'b1;
          cfg_ack_d = (winner == GNT_CFG);
          fwd_ack_d = (winner == GNT_FWD);
          evt_ack_d = (winner == GNT_EVT);
          if (winner == GNT_FWD) evt_last_d = 1'b0;
          if (winner == GNT_EVT) evt_last_d = 1'b1;
        end
      end
      S_LOAD: begin
        state_d    = S_WAIT_START;
        wait_cnt_d = '0;
      end
      S_WAIT_START: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Source was already acked, so a missed start drops the packet.
          state_d = S_IDLE;
          if (timeout_q != 8'hFF) timeout_d = timeout_q + 8'd1;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register (including the payload) is cleared by the synchronous reset.
  always_ff @(posedge txclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_data_q  <= '0;
      grant_q    <= GNT_NONE;
      ld_q       <= 1'b0;
      cfg_ack_q  <= 1'b0;
      fwd_ack_q  <= 1'b0;
      evt_ack_q  <= 1'b0;
      evt_last_q <= 1'b1;
      wait_cnt_q <= '0;
      timeout_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      ld_q       <= ld_d;
      cfg_ack_q  <= cfg_ack_d;
      fwd_ack_q  <= fwd_ack_d;
      evt_ack_q  <= evt_ack_d;
      evt_last_q <= evt_last_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ld_tx_data    = ld_q;
  assign cfg_ack       = cfg_ack_q;
  assign fwd_ack       = fwd_ack_q;
  assign evt_ack       = evt_ack_q;
  assign tx_data       = tx_data_q;
  assign grant         = grant_q;
  assign timeout_count = timeout_q;

endmodule
